// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 4-digit seven-segment display path.
// Used by the anode scanner and the downstream segment decoder.
package seven_seg_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [1:0] digit_idx_t;

   localparam logic [3:0] ANODE_OFF = 4'b1111;
   localparam logic [3:0] ANODE_D0  = 4'b1110;
   localparam logic [3:0] ANODE_D1  = 4'b1101;
   localparam logic [3:0] ANODE_D2  = 4'b1011;
   localparam logic [3:0] ANODE_D3  = 4'b0111;

   function automatic logic [3:0] anode_code(input digit_idx_t digit);
      logic [3:0] code;
      case (digit)
         2'd0:    code = ANODE_D0;
         2'd1:    code = ANODE_D1;
         2'd2:    code = ANODE_D2;
         2'd3:    code = ANODE_D3;
         default: code = ANODE_OFF;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Modulo-TICKS refresh counter with enable; terminal is high while the
// counter sits at TICKS-1 and is enabled, i.e. on the edge that wraps it.
module refresh_tick_gen #(
   parameter int TICKS = 100000
) (
   input  logic                                         clock,
   input  logic                                         reset,
   input  logic                                         enable,
   output logic [((TICKS > 1) ? $clog2(TICKS) : 1)-1:0] count,
   output logic                                         terminal
);

   localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

   logic at_last;

   assign at_last  = (count == LAST);
   assign terminal = enable && at_last;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (enable) begin
         if (at_last) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed active-low anode driver for a 4-digit seven-segment display.
// Optional anti-ghosting blanking at the start of each digit window: ANODE_BLANKING_EN.
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int TICKS_PER_DIGIT = 100000,
   parameter int BLANK_TICKS     = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] digit_mask,
   output logic [3:0] anode,
   output logic [1:0] digit_sel,
   output logic       scan_tick
);

   localparam int CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;

`ifdef ANODE_BLANKING_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   // With blanking off the limit is zero, so the blank compare folds to 0.
   localparam int BLANK_LEN = BLANK_ON ? BLANK_TICKS : 0;
   localparam logic [CW-1:0] BLANK_LIMIT = CW'(BLANK_LEN);

   logic [CW-1:0] count;
   logic          terminal;
   digit_idx_t    digit;
   logic          blank;
   logic [3:0]    anode_next;

   refresh_tick_gen #(
      .TICKS(TICKS_PER_DIGIT)
   ) u_tick_gen (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .count    (count),
      .terminal (terminal)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         digit     <= '0;
         scan_tick <= 1'b0;
      end else begin
         scan_tick <= terminal;
         if (terminal) begin
            if (digit == digit_idx_t'(NUM_DIGITS - 1)) begin
               digit <= '0;
            end else begin
               digit <= digit + 2'd1;
            end
         end
      end
   end

   assign digit_sel = digit;
   assign blank     = (count < BLANK_LIMIT);

   // Built from the pre-edge digit/count, so anode trails digit_sel by a clock.
   always_comb begin
      anode_next = ANODE_OFF;
      if (digit_mask[digit] && !blank) begin
         anode_next = anode_code(digit);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         anode <= ANODE_OFF;
      end else begin
         anode <= anode_next;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner against a tick-count reference model.
module tb_seven_seg_scanner;

  localparam int T = 4;
  localparam int B = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] digit_mask;
  logic [3:0] anode;
  logic [1:0] digit_sel;
  logic       scan_tick;

  int errors = 0;
  int checks = 0;

  // Reference state: number of enabled clock edges since the last reset.
  int unsigned ticks = 0;
  logic [3:0]  exp_q[$];
  logic        exp_tick = 1'b0;

  seven_seg_scanner #(
    .TICKS_PER_DIGIT(T),
    .BLANK_TICKS    (B)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .digit_mask (digit_mask),
    .anode      (anode),
    .digit_sel  (digit_sel),
    .scan_tick  (scan_tick)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] model_anode(input int unsigned t, input logic [3:0] m);
    int unsigned cnt;
    int unsigned d;
    cnt = t % T;
    d = (t / T) % 4;
    if (!m[d]) return 4'b1111;
`ifdef ANODE_BLANKING_EN
    if (cnt < B) return 4'b1111;
`endif
    return ~(4'b0001 << d);
  endfunction

  task automatic compare_all(input string tag);
    logic [3:0] ea;
    logic [1:0] ed;
    ea = exp_q.pop_front();
    ed = 2'((ticks / T) % 4);
    checks++;
    if (anode !== ea) begin
      errors++;
      $display("FAIL %s anode: got %b expected %b (ticks=%0d)", tag, anode, ea, ticks);
    end
    checks++;
    if (digit_sel !== ed) begin
      errors++;
      $display("FAIL %s digit_sel: got %0d expected %0d (ticks=%0d)", tag, digit_sel, ed, ticks);
    end
    checks++;
    if (scan_tick !== exp_tick) begin
      errors++;
      $display("FAIL %s scan_tick: got %b expected %b (ticks=%0d)", tag, scan_tick, exp_tick, ticks);
    end
    checks++;
    if ($countones(~anode) > 1) begin
      errors++;
      $display("FAIL %s one_cold: anode %b has more than one low bit, required at most one", tag, anode);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    if (reset) begin
      ticks = 0;
      exp_q.push_back(4'b1111);
      exp_tick = 1'b0;
    end else begin
      exp_q.push_back(model_anode(ticks, digit_mask));
      exp_tick = enable && ((ticks % T) == T - 1);
      if (enable) ticks++;
    end
    #1;
    compare_all(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    digit_mask = 4'b1111;
    repeat (2) @(posedge clock);
    #1;
    ticks = 0;
    exp_tick = 1'b0;
    exp_q.push_back(4'b1111);
    compare_all("reset");
    enable = 1'b1;
    reset = 1'b0;
  endtask

  task automatic test_scan();
    digit_mask = 4'b1111;
    enable = 1'b1;
    repeat (20) step("scan");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 32 && (ticks % 16) != 10; i++) step("async_pre");
    #2;
    reset = 1'b1;
    #1;
    ticks = 0;
    exp_tick = 1'b0;
    exp_q.push_back(4'b1111);
    compare_all("async_reset");
    #2;
    reset = 1'b0;
    repeat (18) step("async_post");
  endtask

  task automatic test_mask();
    digit_mask = 4'b1011;
    repeat (20) step("mask_1011");
    digit_mask = 4'b1111;
  endtask

  task automatic test_enable_hold();
    int n;
    for (int i = 0; i < 32 && (ticks % 16) != 5; i++) step("hold_pre");
    enable = 1'b0;
    repeat (10) step("hold");
    enable = 1'b1;
    n = 0;
    do begin
      step("resume");
      n++;
    end while (scan_tick !== 1'b1 && n < 2 * T);
    checks++;
    if (n != T - 1 || scan_tick !== 1'b1) begin
      errors++;
      $display("FAIL resume_latency: advance after %0d cycles (scan_tick=%b), expected %0d", n, scan_tick, T - 1);
    end
  endtask

  task automatic test_zero_mask();
    digit_mask = 4'b0000;
    repeat (4 * T) step("mask_0000");
    digit_mask = 4'b0001;
    repeat (4 * T + 4) step("mask_0001");
    digit_mask = 4'b1111;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) digit_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b1;
        step("rand_reset");
        reset = 1'b0;
      end else begin
        step("random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_async_reset();
    test_mask();
    test_enable_hold();
    test_zero_mask();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
